// File: rtl/noc_output_allocator.sv
// Per-output switch allocator: round-robin arbitration with packet locking from
// HEAD through TAIL, per-VC downstream credit tracking and crossbar select.
module noc_output_allocator #(
  parameter int PORT_NUM     = 9,
  parameter int VC_NUM       = 2,
  parameter int BUFFER_DEPTH = 4,
  parameter int VC_SIZE      = $clog2(VC_NUM),
  parameter int PORT_SIZE    = $clog2(PORT_NUM),
  parameter int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORT_NUM-1:0]         req_i,
  input  logic [PORT_NUM*VC_SIZE-1:0] req_vc_i,
  input  logic [PORT_NUM*2-1:0]       req_label_i,
  input  logic [VC_NUM-1:0]           credit_i,
  output logic [PORT_NUM-1:0]         grant_o,
  output logic                        valid_o,
  output logic [PORT_SIZE-1:0]        sel_o,
  output logic [VC_SIZE-1:0]          out_vc_o,
  output logic                        locked_o,
  output logic [VC_NUM*CNT_W-1:0]     credit_cnt_o,
  output logic                        proto_err_o
);

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;

  logic [CNT_W-1:0]     credit [VC_NUM];
  logic                 lock;
  logic [PORT_SIZE-1:0] owner;
  logic [VC_SIZE-1:0]   lock_vc;
  logic [PORT_SIZE-1:0] rr_ptr;
  logic                 proto_err_q;

  logic [VC_SIZE-1:0]   vc_p0    [PORT_NUM];
  flit_label_t          label_p0 [PORT_NUM];
  logic [PORT_NUM-1:0]  elig_p0;
  logic [PORT_SIZE:0]   scan_idx;
  logic [PORT_SIZE-1:0] gnt_idx_p0;
  logic [PORT_SIZE-1:0] rr_next_p0;
  logic [VC_SIZE-1:0]   gnt_vc_p0;
  logic                 vld_p0;
  logic                 err_p0;

  // Saturating credit update; a grant only happens with credit > 0 so no underflow.
  function automatic logic [CNT_W-1:0] credit_update(input logic [CNT_W-1:0] cnt,
                                                     input logic take, input logic give);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(give) - (CNT_W+1)'(take);
    if (sum > (CNT_W+1)'(BUFFER_DEPTH)) sum = (CNT_W+1)'(BUFFER_DEPTH);
    return sum[CNT_W-1:0];
  endfunction

  // Stage p0: eligibility, round-robin scan and error detection (all same-cycle)
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      vc_p0[i]    = req_vc_i[i*VC_SIZE +: VC_SIZE];
      label_p0[i] = flit_label_t'(req_label_i[i*2 +: 2]);
    end
  end

  always_comb begin
    elig_p0 = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (lock)
        elig_p0[i] = req_i[i] && (PORT_SIZE'(i) == owner) &&
                     (label_p0[i] == BODY || label_p0[i] == TAIL) && (credit[lock_vc] != '0);
      else
        elig_p0[i] = req_i[i] && (label_p0[i] == HEAD || label_p0[i] == HEADTAIL) &&
                     (credit[vc_p0[i]] != '0);
    end
  end

  always_comb begin
    vld_p0     = 1'b0;
    gnt_idx_p0 = '0;
    scan_idx   = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PORT_SIZE+1)'(k);
      if (scan_idx >= (PORT_SIZE+1)'(PORT_NUM)) scan_idx = scan_idx - (PORT_SIZE+1)'(PORT_NUM);
      if (!vld_p0 && elig_p0[scan_idx[PORT_SIZE-1:0]]) begin
        vld_p0     = 1'b1;
        gnt_idx_p0 = scan_idx[PORT_SIZE-1:0];
      end
    end
    if (rst) begin
      vld_p0     = 1'b0;
      gnt_idx_p0 = '0;
    end
  end

  assign gnt_vc_p0  = lock ? lock_vc : vc_p0[gnt_idx_p0];
  assign rr_next_p0 = (gnt_idx_p0 == PORT_SIZE'(PORT_NUM - 1)) ? '0 : gnt_idx_p0 + 1'b1;

  always_comb begin
    err_p0 = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (req_i[i] && !lock && (label_p0[i] == BODY || label_p0[i] == TAIL)) err_p0 = 1'b1;
      if (req_i[i] && lock && (PORT_SIZE'(i) == owner) &&
          (label_p0[i] == HEAD || label_p0[i] == HEADTAIL)) err_p0 = 1'b1;
    end
    for (int v = 0; v < VC_NUM; v++) begin
      if (credit_i[v] && (credit[v] == CNT_W'(BUFFER_DEPTH)) &&
          !(vld_p0 && gnt_vc_p0 == VC_SIZE'(v))) err_p0 = 1'b1;
    end
  end

  always_comb begin
    grant_o = '0;
    if (vld_p0) grant_o[gnt_idx_p0] = 1'b1;
    for (int v = 0; v < VC_NUM; v++) credit_cnt_o[v*CNT_W +: CNT_W] = credit[v];
  end

  assign valid_o     = vld_p0;
  assign sel_o       = vld_p0 ? gnt_idx_p0 : '0;
  assign out_vc_o    = rst ? '0 : (lock ? lock_vc : (vld_p0 ? vc_p0[gnt_idx_p0] : '0));
  assign locked_o    = lock & ~rst;
  assign proto_err_o = proto_err_q & ~rst;

  // Stage p1: registered allocation state
  always_ff @(posedge clk) begin
    if (rst) begin
      lock        <= 1'b0;
      owner       <= '0;
      lock_vc     <= '0;
      rr_ptr      <= '0;
      proto_err_q <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) credit[v] <= CNT_W'(BUFFER_DEPTH);
    end else begin
      proto_err_q <= err_p0;
      for (int v = 0; v < VC_NUM; v++)
        credit[v] <= credit_update(credit[v], vld_p0 && (gnt_vc_p0 == VC_SIZE'(v)), credit_i[v]);
      if (vld_p0) begin
        if (lock) begin
          if (label_p0[owner] == TAIL) lock <= 1'b0;
        end else begin
          rr_ptr <= rr_next_p0;
          if (label_p0[gnt_idx_p0] == HEAD) begin
            lock    <= 1'b1;
            owner   <= gnt_idx_p0;
            lock_vc <= vc_p0[gnt_idx_p0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_output_allocator.sv
// Directed bench for noc_output_allocator: reset, round-robin, packet lock,
// credit stall/return, overflow error and reset mid-packet.
module tb_noc_output_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  req;
  logic [8:0]  req_vc;
  logic [17:0] req_label;
  logic [1:0]  credit_in;
  logic [8:0]  grant;
  logic        valid;
  logic [3:0]  sel;
  logic [0:0]  out_vc;
  logic        locked;
  logic [5:0]  credit_cnt;
  logic        proto_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam int HEAD = 0, BODY = 1, TAIL = 2, HT = 3;

  noc_output_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .req_vc_i     (req_vc),
    .req_label_i  (req_label),
    .credit_i     (credit_in),
    .grant_o      (grant),
    .valid_o      (valid),
    .sel_o        (sel),
    .out_vc_o     (out_vc),
    .locked_o     (locked),
    .credit_cnt_o (credit_cnt),
    .proto_err_o  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    req       = '0;
    req_vc    = '0;
    req_label = '0;
  endtask

  task automatic set_req(input int p, input int vc, input int lab);
    logic [1:0] l;
    l = 2'(lab);
    req[p]             = 1'b1;
    req_vc[p]          = vc[0];
    req_label[p*2 +: 2] = l;
  endtask

  function automatic logic [31:0] cc(input int c1, input int c0);
    return 32'(c1 * 8 + c0);
  endfunction

  task automatic expect_grant(input string tag, input int p);
    logic [8:0] oh;
    oh = 9'(1 << p);
    chk({tag, "_grant"}, 32'(grant), 32'(oh));
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'(p));
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
  endtask

  initial begin
    // Reset with every port requesting
    rst = 1'b1; credit_in = '0; clr_req();
    for (int p = 0; p < 9; p++) set_req(p, 0, HEAD);
    #1;
    expect_none("rst_c0");
    chk("rst_c0_outvc", 32'(out_vc), 32'd0);
    cyc();
    expect_none("rst_c1");
    chk("rst_c1_locked", 32'(locked), 32'd0);
    chk("rst_c1_err", 32'(proto_err), 32'd0);
    cyc();
    rst = 1'b0; clr_req();
    #1;
    chk("rel_cnt", 32'(credit_cnt), cc(4, 4));
    chk("rel_locked", 32'(locked), 32'd0);
    chk("rel_err", 32'(proto_err), 32'd0);
    expect_none("rel");

    // Round-robin among HEADTAIL requests on VC0
    set_req(0, 0, HT); set_req(2, 0, HT); set_req(5, 0, HT);
    #1;
    expect_grant("rr0", 0);
    chk("rr0_outvc", 32'(out_vc), 32'd0);
    cyc();
    credit_in = 2'b01; #1;
    expect_grant("rr1", 2);
    chk("rr1_cnt", 32'(credit_cnt), cc(4, 3));
    chk("rr1_locked", 32'(locked), 32'd0);
    cyc(); #1;
    expect_grant("rr2", 5);
    chk("rr2_cnt", 32'(credit_cnt), cc(4, 3));
    cyc(); #1;
    expect_grant("rr3", 0);
    cyc();
    clr_req(); #1;
    expect_none("rr_idle");
    chk("rr_idle_cnt", 32'(credit_cnt), cc(4, 3));
    cyc();
    credit_in = '0; #1;
    chk("rr_refill_cnt", 32'(credit_cnt), cc(4, 4));
    chk("rr_refill_err", 32'(proto_err), 32'd0);

    // Packet lock: port 3 HEAD..TAIL on VC1 while port 7 waits with HEAD
    set_req(3, 1, HEAD); set_req(7, 0, HEAD);
    #1;
    expect_grant("lk_head", 3);
    chk("lk_head_vc", 32'(out_vc), 32'd1);
    chk("lk_head_locked", 32'(locked), 32'd0);
    cyc();
    set_req(3, 0, BODY); #1;
    expect_grant("lk_b1", 3);
    chk("lk_b1_vc", 32'(out_vc), 32'd1);
    chk("lk_b1_locked", 32'(locked), 32'd1);
    chk("lk_b1_cnt", 32'(credit_cnt), cc(3, 4));
    cyc(); #1;
    expect_grant("lk_b2", 3);
    chk("lk_b2_err", 32'(proto_err), 32'd0);
    cyc();
    set_req(3, 1, TAIL); #1;
    expect_grant("lk_tail", 3);
    chk("lk_tail_locked", 32'(locked), 32'd1);
    cyc();
    req[3] = 1'b0; #1;
    expect_grant("lk_p7", 7);
    chk("lk_p7_locked", 32'(locked), 32'd0);
    chk("lk_p7_cnt", 32'(credit_cnt), cc(0, 4));
    chk("lk_p7_vc", 32'(out_vc), 32'd0);
    cyc();
    set_req(7, 0, TAIL); #1;
    expect_grant("lk_p7t", 7);
    cyc();
    clr_req(); #1;
    chk("lk_end_cnt", 32'(credit_cnt), cc(0, 2));
    chk("lk_end_locked", 32'(locked), 32'd0);
    chk("lk_end_err", 32'(proto_err), 32'd0);

    // Drain VC0 with two HEADTAIL flits from port 8
    set_req(8, 0, HT); #1;
    expect_grant("dr0", 8);
    cyc(); #1;
    expect_grant("dr1", 8);
    cyc();

    // Credit stall on VC0: returned credit enables the grant one cycle later
    clr_req(); set_req(1, 0, HEAD); #1;
    expect_none("st_wait");
    chk("st_wait_cnt", 32'(credit_cnt), cc(0, 0));
    cyc();
    credit_in = 2'b01; #1;
    expect_none("st_same");
    cyc();
    credit_in = '0; #1;
    expect_grant("st_go", 1);
    chk("st_go_cnt", 32'(credit_cnt), cc(0, 1));
    cyc(); #1;
    chk("st_after_cnt", 32'(credit_cnt), cc(0, 0));

    // Owner gap: lock held, other ports wait without error
    clr_req(); credit_in = 2'b11; #1;
    expect_none("gap0");
    chk("gap0_locked", 32'(locked), 32'd1);
    cyc(); cyc();
    set_req(2, 1, HT); #1;
    expect_none("gap_other");
    chk("gap_other_locked", 32'(locked), 32'd1);
    chk("gap_other_cnt", 32'(credit_cnt), cc(2, 2));
    cyc();
    credit_in = '0; set_req(1, 1, TAIL); #1;
    expect_grant("gap_tail", 1);
    chk("gap_tail_vc", 32'(out_vc), 32'd0);
    chk("gap_tail_err", 32'(proto_err), 32'd0);
    chk("gap_tail_cnt", 32'(credit_cnt), cc(3, 3));
    cyc();
    req[1] = 1'b0; #1;
    expect_grant("rr_after", 2);
    chk("rr_after_vc", 32'(out_vc), 32'd1);
    chk("rr_after_locked", 32'(locked), 32'd0);
    cyc();

    // Simultaneous grant and return on VC0 at count 2
    clr_req(); set_req(0, 0, HT); credit_in = 2'b01; #1;
    expect_grant("sim", 0);
    chk("sim_cnt_pre", 32'(credit_cnt), cc(2, 2));
    cyc();
    clr_req(); credit_in = '0; #1;
    chk("sim_cnt_post", 32'(credit_cnt), cc(2, 2));

    // Credit overflow on VC1
    credit_in = 2'b10;
    cyc(); cyc(); #1;
    chk("ovf_at4_err", 32'(proto_err), 32'd0);
    chk("ovf_at4_cnt", 32'(credit_cnt), cc(4, 2));
    cyc();
    credit_in = '0; #1;
    chk("ovf_err_pulse", 32'(proto_err), 32'd1);
    chk("ovf_cnt_sat", 32'(credit_cnt), cc(4, 2));
    cyc(); #1;
    chk("ovf_err_clear", 32'(proto_err), 32'd0);

    // BODY while unlocked: never granted, flagged next cycle
    set_req(5, 0, BODY); #1;
    expect_none("body_unl");
    cyc();
    clr_req(); #1;
    chk("body_unl_err", 32'(proto_err), 32'd1);

    // Reset in the middle of a port 4 packet
    set_req(4, 1, HEAD); #1;
    expect_grant("rm_head", 4);
    cyc();
    set_req(4, 1, BODY); #1;
    expect_grant("rm_body", 4);
    chk("rm_body_locked", 32'(locked), 32'd1);
    cyc();
    chk("rm_pre_cnt", 32'(credit_cnt), cc(2, 2));
    rst = 1'b1; #1;
    expect_none("rm_rst");
    chk("rm_rst_locked", 32'(locked), 32'd0);
    cyc();
    rst = 1'b0; clr_req(); set_req(6, 0, HEAD); #1;
    chk("rm_post_locked", 32'(locked), 32'd0);
    chk("rm_post_cnt", 32'(credit_cnt), cc(4, 4));
    chk("rm_post_err", 32'(proto_err), 32'd0);
    expect_grant("rm_post", 6);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
